// File: rtl/noc_pkg.sv
// Shared NoC definitions used by enh_demux and enh_mux.
//   - default flit geometry constants
//   - drop counter width
//   - route selector encoding
//   - flit_valid(): OR-reduction of the valid field at the flit MSBs
package noc_pkg;

    localparam int unsigned DefWordWidth    = 17;
    localparam int unsigned DefValBit       = 1;
    localparam int unsigned DefLogBufferLen = 2;
    localparam int unsigned DropCntWidth    = 8;

    // Upper bound on flit width accepted by flit_valid().
    localparam int unsigned MaxWordWidth = 64;

    typedef enum logic {
        RouteOut1 = 1'b0,
        RouteOut2 = 1'b1
    } route_e;

    // A flit is valid when any bit of its top vb bits (below width ww) is set.
    function automatic logic flit_valid(input logic [MaxWordWidth-1:0] flit,
                                        input int unsigned ww,
                                        input int unsigned vb);
        logic v;
        v = 1'b0;
        for (int unsigned i = 0; i < MaxWordWidth; i++) begin
            if ((i < ww) && ((i + vb) >= ww)) begin
                v = v | flit[i];
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/flit_fifo.sv
// Synchronous flit FIFO with registered storage and combinational head.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   push_i        write data_i this edge (ignored when full)
//   data_i        flit to write
//   pop_i         consume head this edge (ignored when empty)
//   head_o        head flit, all-zero when empty
//   count_o       occupancy, 0..2**log_buffer_len
//   full_o        occupancy == depth
module flit_fifo #(
    parameter int unsigned word_width     = 17,
    parameter int unsigned log_buffer_len = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push_i,
    input  logic [word_width-1:0]     data_i,
    input  logic                      pop_i,
    output logic [word_width-1:0]     head_o,
    output logic [log_buffer_len:0]   count_o,
    output logic                      full_o
);

    localparam int unsigned Depth = 1 << log_buffer_len;
    localparam logic [log_buffer_len:0] DepthCnt = {1'b1, {log_buffer_len{1'b0}}};

    logic [word_width-1:0]     mem_q [Depth];
    logic [word_width-1:0]     mem_d [Depth];
    logic [log_buffer_len-1:0] wr_ptr_q, wr_ptr_d;
    logic [log_buffer_len-1:0] rd_ptr_q, rd_ptr_d;
    logic [log_buffer_len:0]   count_q, count_d;
    logic                      do_push, do_pop;

    // Fullness is judged on the registered count, so a same-edge pop never
    // makes room for a push.
    assign full_o  = (count_q == DepthCnt);
    assign count_o = count_q;
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & (count_q != '0);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        head_o = '0;
        if (count_q != '0) begin
            head_o = mem_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/enh_demux.sv
// Two-way flit demultiplexer: steers valid flits by a payload route bit into
// one of two FIFOs and reports upstream backpressure and overflow drops.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   in                 incoming flit (valid field at MSBs)
//   stall_1, stall_2   downstream of out_1/out_2 cannot accept this edge
//   out_1, out_2       FIFO head flits, all-zero when empty
//   full               either FIFO holds depth entries
//   drop_cnt           saturating count of flits lost to a full FIFO
module enh_demux
    import noc_pkg::*;
#(
    parameter int unsigned word_width     = DefWordWidth,
    parameter int unsigned val_bit        = DefValBit,
    parameter int unsigned log_buffer_len = DefLogBufferLen,
    parameter int unsigned route_bit      = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [word_width-1:0]   in,
    input  logic                    stall_1,
    input  logic                    stall_2,
    output logic [word_width-1:0]   out_1,
    output logic [word_width-1:0]   out_2,
    output logic                    full,
    output logic [DropCntWidth-1:0] drop_cnt
);

    localparam logic [log_buffer_len:0] DepthCnt = {1'b1, {log_buffer_len{1'b0}}};

    logic                    in_valid;
    route_e                  route;
    logic                    push_1, push_2;
    logic                    fifo_full_1, fifo_full_2;
    logic [log_buffer_len:0] count_1, count_2;
    logic                    drop;
    logic [DropCntWidth-1:0] drop_cnt_q, drop_cnt_d;

    assign in_valid = flit_valid(MaxWordWidth'(in), word_width, val_bit);
    assign route    = route_e'(in[route_bit]);
    assign push_1   = in_valid & (route == RouteOut1);
    assign push_2   = in_valid & (route == RouteOut2);
    assign drop     = (push_1 & fifo_full_1) | (push_2 & fifo_full_2);

    // Conservative: one full FIFO blocks traffic to both destinations.
    assign full     = (count_1 == DepthCnt) | (count_2 == DepthCnt);
    assign drop_cnt = drop_cnt_q;

    flit_fifo #(
        .word_width     (word_width),
        .log_buffer_len (log_buffer_len)
    ) u_fifo_1 (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_1),
        .data_i  (in),
        .pop_i   (~stall_1),
        .head_o  (out_1),
        .count_o (count_1),
        .full_o  (fifo_full_1)
    );

    flit_fifo #(
        .word_width     (word_width),
        .log_buffer_len (log_buffer_len)
    ) u_fifo_2 (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_2),
        .data_i  (in),
        .pop_i   (~stall_2),
        .head_o  (out_2),
        .count_o (count_2),
        .full_o  (fifo_full_2)
    );

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

endmodule

// File: tb/tb_enh_demux.sv
module tb_enh_demux;

    logic        clk;
    logic        rst;
    logic [16:0] in;
    logic        stall_1;
    logic        stall_2;
    logic [16:0] out_1;
    logic [16:0] out_2;
    logic        full;
    logic [7:0]  drop_cnt;

    int n_checks;
    int n_fail;

    typedef struct {
        logic [16:0] in;
        logic        s1;
        logic        s2;
        logic [16:0] e1;
        logic [16:0] e2;
        logic        ef;
        logic [7:0]  ed;
    } vec_t;

    vec_t vecs[$];

    enh_demux u_dut (
        .clk      (clk),
        .rst      (rst),
        .in       (in),
        .stall_1  (stall_1),
        .stall_2  (stall_2),
        .out_1    (out_1),
        .out_2    (out_2),
        .full     (full),
        .drop_cnt (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic [16:0] i, input logic s1, input logic s2,
                       input logic [16:0] e1, input logic [16:0] e2,
                       input logic ef, input logic [7:0] ed);
        vec_t v;
        v.in = i; v.s1 = s1; v.s2 = s2; v.e1 = e1; v.e2 = e2; v.ef = ef; v.ed = ed;
        vecs.push_back(v);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        //   in        s1  s2  out_1     out_2     full drop
        // single flits on each route, invalid flit ignored
        add(17'h10002, 0, 0, 17'h10002, 17'h0,     0, 0);
        add(17'h00000, 0, 0, 17'h0,     17'h0,     0, 0);
        add(17'h10001, 0, 0, 17'h0,     17'h10001, 0, 0);
        add(17'h0FFFF, 0, 1, 17'h0,     17'h10001, 0, 0);
        add(17'h00000, 0, 0, 17'h0,     17'h0,     0, 0);
        // fill FIFO 1 under stall, fifth flit dropped
        add(17'h10000, 1, 0, 17'h10000, 17'h0,     0, 0);
        add(17'h10002, 1, 0, 17'h10000, 17'h0,     0, 0);
        add(17'h10004, 1, 0, 17'h10000, 17'h0,     0, 0);
        add(17'h10006, 1, 0, 17'h10000, 17'h0,     1, 0);
        add(17'h10008, 1, 0, 17'h10000, 17'h0,     1, 1);
        // drain in order, full drops after first pop
        add(17'h00000, 0, 0, 17'h10002, 17'h0,     0, 1);
        add(17'h00000, 0, 0, 17'h10004, 17'h0,     0, 1);
        add(17'h00000, 0, 0, 17'h10006, 17'h0,     0, 1);
        add(17'h00000, 0, 0, 17'h0,     17'h0,     0, 1);
        // alternating routes with stall_2 toggling: no loss
        add(17'h1A0A0, 0, 1, 17'h1A0A0, 17'h0,     0, 1);
        add(17'h1B0B1, 0, 0, 17'h0,     17'h1B0B1, 0, 1);
        add(17'h1A0A0, 0, 1, 17'h1A0A0, 17'h1B0B1, 0, 1);
        add(17'h1B0B1, 0, 0, 17'h0,     17'h1B0B1, 0, 1);
        add(17'h00000, 0, 1, 17'h0,     17'h1B0B1, 0, 1);
        add(17'h00000, 0, 0, 17'h0,     17'h0,     0, 1);
        // full FIFO 1 with simultaneous pop and push: push dropped, count 3
        add(17'h10010, 1, 0, 17'h10010, 17'h0,     0, 1);
        add(17'h10012, 1, 0, 17'h10010, 17'h0,     0, 1);
        add(17'h10014, 1, 0, 17'h10010, 17'h0,     0, 1);
        add(17'h10016, 1, 0, 17'h10010, 17'h0,     1, 1);
        add(17'h10018, 0, 0, 17'h10012, 17'h0,     0, 2);
        add(17'h00000, 1, 0, 17'h10012, 17'h0,     0, 2);
        // partly fill FIFO 2 ahead of the mid-stream reset
        add(17'h10021, 1, 1, 17'h10012, 17'h10021, 0, 2);

        rst = 1'b1; in = '0; stall_1 = 1'b0; stall_2 = 1'b0;
        repeat (2) @(negedge clk);
        check("reset out_1", 32'(out_1), 32'h0);
        check("reset out_2", 32'(out_2), 32'h0);
        check("reset full", 32'(full), 32'h0);
        check("reset drop_cnt", 32'(drop_cnt), 32'h0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            in = vecs[i].in; stall_1 = vecs[i].s1; stall_2 = vecs[i].s2;
            @(posedge clk);
            #1;
            check($sformatf("v%0d out_1", i), 32'(out_1), 32'(vecs[i].e1));
            check($sformatf("v%0d out_2", i), 32'(out_2), 32'(vecs[i].e2));
            check($sformatf("v%0d full", i), 32'(full), 32'(vecs[i].ef));
            check($sformatf("v%0d drop_cnt", i), 32'(drop_cnt), 32'(vecs[i].ed));
        end

        // asynchronous reset mid-cycle, both FIFOs holding data
        @(negedge clk);
        in = 17'h10022; stall_1 = 1'b1; stall_2 = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("async rst out_1", 32'(out_1), 32'h0);
        check("async rst out_2", 32'(out_2), 32'h0);
        check("async rst full", 32'(full), 32'h0);
        check("async rst drop_cnt", 32'(drop_cnt), 32'h0);
        @(negedge clk);
        rst = 1'b0; in = 17'h10030; stall_1 = 1'b0; stall_2 = 1'b0;
        #1;
        check("post rst pre-edge out_1", 32'(out_1), 32'h0);
        @(posedge clk);
        #1;
        check("post rst out_1", 32'(out_1), 32'h10030);
        check("post rst out_2", 32'(out_2), 32'h0);
        @(negedge clk);
        in = '0;
        @(posedge clk);
        #1;
        check("post rst drain out_1", 32'(out_1), 32'h0);

        // drop counter saturation: 4 writes then 260 drops
        @(negedge clk);
        in = 17'h10040; stall_1 = 1'b1;
        repeat (264) @(posedge clk);
        #1;
        check("sat drop_cnt", 32'(drop_cnt), 32'd255);
        check("sat full", 32'(full), 32'h1);
        check("sat out_1", 32'(out_1), 32'h10040);
        @(negedge clk);
        in = '0; stall_1 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
